// File: rtl/sum_bcd_display.sv
// Captures a 5-bit sum, converts it to two BCD digits with a serial double-dabble FSM,
// and scans both digits onto a common-anode 7-segment pair. Option: SUM_BCD_BLANK_LEADING_ZERO_EN.
module sum_bcd_display #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] sum_in,
  input  logic       load,
  output logic       busy,
  output logic       done,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_units,
  output logic [6:0] seg,
  output logic [1:0] an
);

  // state | meaning
  // IDLE  | waiting for load; committed digits on display
  // CONV  | one double-dabble iteration per cycle, five in total
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_CONV = 1'b1;

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [0:0] state_q, state_d;
  logic [4:0] shift_q, shift_d;
  logic [7:0] scratch_q, scratch_d;
  logic [2:0] iter_q, iter_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] units_q, units_d;

  logic [3:0] tens_adj, units_adj;
  logic [7:0] scratch_next;
  logic [4:0] shift_next;

  logic [CW-1:0] scan_cnt_q;
  logic          sel_tens_q;

  always_comb begin
    tens_adj     = (scratch_q[7:4] >= 4'd5) ? scratch_q[7:4] + 4'd3 : scratch_q[7:4];
    units_adj    = (scratch_q[3:0] >= 4'd5) ? scratch_q[3:0] + 4'd3 : scratch_q[3:0];
    // {scratch, shift} shifts left as one 13-bit value
    scratch_next = {tens_adj[2:0], units_adj, shift_q[4]};
    shift_next   = {shift_q[3:0], 1'b0};
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    iter_d    = iter_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    tens_d    = tens_q;
    units_d   = units_q;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          shift_d   = sum_in;
          scratch_d = 8'h00;
          iter_d    = 3'd0;
          busy_d    = 1'b1;
          state_d   = S_CONV;
        end
      end
      S_CONV: begin
        scratch_d = scratch_next;
        shift_d   = shift_next;
        iter_d    = iter_q + 3'd1;
        if (iter_q == 3'd4) begin
          tens_d  = scratch_next[7:4];
          units_d = scratch_next[3:0];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      shift_q   <= 5'd0;
      scratch_q <= 8'h00;
      iter_q    <= 3'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tens_q    <= 4'd0;
      units_q   <= 4'd0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      iter_q    <= iter_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      tens_q    <= tens_d;
      units_q   <= units_d;
    end
  end

  // Scan runs freely, independent of the conversion FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt_q <= '0;
      sel_tens_q <= 1'b0;
    end else if (scan_cnt_q == CW'(REFRESH_DIV - 1)) begin
      scan_cnt_q <= '0;
      sel_tens_q <= ~sel_tens_q;
    end else begin
      scan_cnt_q <= scan_cnt_q + CW'(1);
    end
  end

  function automatic logic [6:0] seg_pattern(input logic [3:0] d);
    case (d)
      4'd0:    seg_pattern = 7'b1000000;
      4'd1:    seg_pattern = 7'b1111001;
      4'd2:    seg_pattern = 7'b0100100;
      4'd3:    seg_pattern = 7'b0110000;
      4'd4:    seg_pattern = 7'b0011001;
      4'd5:    seg_pattern = 7'b0010010;
      4'd6:    seg_pattern = 7'b0000010;
      4'd7:    seg_pattern = 7'b1111000;
      4'd8:    seg_pattern = 7'b0000000;
      4'd9:    seg_pattern = 7'b0010000;
      default: seg_pattern = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    if (sel_tens_q) begin
      an = 2'b01;
`ifdef SUM_BCD_BLANK_LEADING_ZERO_EN
      seg = (tens_q == 4'd0) ? 7'b1111111 : seg_pattern(tens_q);
`else
      seg = seg_pattern(tens_q);
`endif
    end else begin
      an  = 2'b10;
      seg = seg_pattern(units_q);
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign bcd_tens  = tens_q;
  assign bcd_units = units_q;

endmodule

// File: tb/tb_sum_bcd_display.sv
// Scoreboard bench for sum_bcd_display (REFRESH_DIV=4); honours SUM_BCD_BLANK_LEADING_ZERO_EN.
module tb_sum_bcd_display;

  logic       clk;
  logic       rst_n;
  logic [4:0] sum_in;
  logic       load;
  logic       busy;
  logic       done;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_units;
  logic [6:0] seg;
  logic [1:0] an;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  sum_bcd_display #(.REFRESH_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .sum_in(sum_in), .load(load),
    .busy(busy), .done(done), .bcd_tens(bcd_tens), .bcd_units(bcd_units),
    .seg(seg), .an(an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: pat = 7'b1000000;
      1: pat = 7'b1111001;
      2: pat = 7'b0100100;
      3: pat = 7'b0110000;
      4: pat = 7'b0011001;
      5: pat = 7'b0010010;
      6: pat = 7'b0000010;
      7: pat = 7'b1111000;
      8: pat = 7'b0000000;
      9: pat = 7'b0010000;
      default: pat = 7'b1111111;
    endcase
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; load = 1'b0; sum_in = 5'd0;
    tick(); tick();
    rst_n = 1'b1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if ({bcd_tens, bcd_units} !== 8'h00) begin failures++; $display("FAIL reset_bcd got=%h exp=00", {bcd_tens, bcd_units}); end
    checks++; if (an !== 2'b10) begin failures++; $display("FAIL reset_an got=%b exp=10", an); end
    checks++; if (seg !== 7'b1000000) begin failures++; $display("FAIL reset_seg got=%b exp=1000000", seg); end
  endtask

  task automatic test_conversion();
    logic [7:0] e;
    sum_in = 5'd27; load = 1'b1; tick(); load = 1'b0;
    exp_q.push_back({4'd2, 4'd7});
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++; if (busy !== 1'b1 || done !== 1'b0) begin
        failures++; $display("FAIL conv_busy edge=%0d got busy=%b done=%b exp busy=1 done=0", i, busy, done);
      end
      checks++; if ({bcd_tens, bcd_units} !== 8'h00) begin
        failures++; $display("FAIL conv_hold edge=%0d got=%h exp=00", i, {bcd_tens, bcd_units});
      end
    end
    tick();
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL conv_done got done=%b busy=%b exp done=1 busy=0", done, busy);
    end
    e = exp_q.pop_front();
    checks++; if ({bcd_tens, bcd_units} !== e) begin
      failures++; $display("FAIL conv_bcd got=%h exp=%h", {bcd_tens, bcd_units}, e);
    end
    tick();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL conv_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_sweep();
    logic [7:0] e;
    int lat;
    logic got;
    for (int s = 0; s < 32; s++) begin
      sum_in = 5'(s); load = 1'b1; tick(); load = 1'b0;
      exp_q.push_back({4'(s / 10), 4'(s % 10)});
      got = 1'b0; lat = 0;
      for (int t = 1; t <= 8; t++) begin
        tick();
        if (done === 1'b1) begin got = 1'b1; lat = t; break; end
      end
      e = exp_q.pop_front();
      checks++;
      if (!got) begin
        failures++; $display("FAIL sweep_timeout sum=%0d no done within 8 cycles", s);
      end else if ({bcd_tens, bcd_units} !== e || lat != 5) begin
        failures++; $display("FAIL sweep sum=%0d got=%h lat=%0d exp=%h lat=5", s, {bcd_tens, bcd_units}, lat, e);
      end
    end
  endtask

  task automatic test_ignored_loads();
    logic [7:0] e;
    int lat;
    logic got;
    sum_in = 5'd9; load = 1'b1; tick(); load = 1'b0;
    exp_q.push_back(8'h09);
    tick();
    sum_in = 5'd30; load = 1'b1; tick(); load = 1'b0;
    got = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (done === 1'b1) begin got = 1'b1; break; end
    end
    e = exp_q.pop_front();
    checks++;
    if (!got) begin failures++; $display("FAIL ignore_timeout no done for sum 9"); end
    else if ({bcd_tens, bcd_units} !== e) begin
      failures++; $display("FAIL ignore_busy_load got=%h exp=%h", {bcd_tens, bcd_units}, e);
    end
    // load presented in the done cycle must be accepted
    sum_in = 5'd30; load = 1'b1; tick(); load = 1'b0;
    exp_q.push_back(8'h30);
    got = 1'b0; lat = 0;
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (done === 1'b1) begin got = 1'b1; lat = t; break; end
    end
    e = exp_q.pop_front();
    checks++;
    if (!got) begin failures++; $display("FAIL done_cycle_load_timeout no done for sum 30"); end
    else if ({bcd_tens, bcd_units} !== e || lat != 5) begin
      failures++; $display("FAIL done_cycle_load got=%h lat=%0d exp=%h lat=5", {bcd_tens, bcd_units}, lat, e);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] e;
    logic [1:0] ea;
    logic got;
    int ndone;
    sum_in = 5'd19; load = 1'b1; tick(); load = 1'b0;
    tick(); tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL midrst_flags got busy=%b done=%b exp 0 0", busy, done);
    end
    checks++; if ({bcd_tens, bcd_units} !== 8'h00) begin
      failures++; $display("FAIL midrst_bcd got=%h exp=00", {bcd_tens, bcd_units});
    end
    checks++; if (an !== 2'b10 || seg !== 7'b1000000) begin
      failures++; $display("FAIL midrst_display got an=%b seg=%b exp an=10 seg=1000000", an, seg);
    end
    ndone = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (done === 1'b1) ndone++;
      ea = (((i / 4) % 2) == 0) ? 2'b10 : 2'b01;
      checks++; if (an !== ea) begin
        failures++; $display("FAIL midrst_scan edge=%0d got an=%b exp=%b", i, an, ea);
      end
    end
    checks++; if (ndone != 0) begin failures++; $display("FAIL midrst_no_done got=%0d pulses exp=0", ndone); end
    sum_in = 5'd5; load = 1'b1; tick(); load = 1'b0;
    exp_q.push_back(8'h05);
    got = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (done === 1'b1) begin got = 1'b1; break; end
    end
    e = exp_q.pop_front();
    checks++;
    if (!got) begin failures++; $display("FAIL midrst_reload_timeout no done for sum 5"); end
    else if ({bcd_tens, bcd_units} !== e) begin
      failures++; $display("FAIL midrst_reload got=%h exp=%h", {bcd_tens, bcd_units}, e);
    end
  endtask

  task automatic test_scan();
    logic [7:0] e;
    logic [6:0] es, tens_blank;
    logic [1:0] ea;
    int n, n_load;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    n = 0;
    sum_in = 5'd27; load = 1'b1; tick(); load = 1'b0; n++;
    exp_q.push_back(8'h27);
    n_load = n;
    while (n < 24) begin
      tick(); n++;
      ea = (((n / 4) % 2) == 0) ? 2'b10 : 2'b01;
      checks++; if (an !== ea) begin
        failures++; $display("FAIL scan_an edge=%0d got=%b exp=%b", n, an, ea);
      end
      if (n == n_load + 5) begin
        e = exp_q.pop_front();
        checks++; if (done !== 1'b1 || {bcd_tens, bcd_units} !== e) begin
          failures++; $display("FAIL scan_conv got done=%b bcd=%h exp done=1 bcd=%h", done, {bcd_tens, bcd_units}, e);
        end
      end
      if (n >= n_load + 5) begin
        es = (ea == 2'b10) ? pat(7) : pat(2);
        checks++; if (seg !== es) begin
          failures++; $display("FAIL scan_seg27 edge=%0d an=%b got=%b exp=%b", n, an, seg, es);
        end
      end
    end
`ifdef SUM_BCD_BLANK_LEADING_ZERO_EN
    tens_blank = 7'b1111111;
`else
    tens_blank = pat(0);
`endif
    sum_in = 5'd7; load = 1'b1; tick(); load = 1'b0; n++;
    exp_q.push_back(8'h07);
    n_load = n;
    while (n < n_load + 16) begin
      tick(); n++;
      ea = (((n / 4) % 2) == 0) ? 2'b10 : 2'b01;
      checks++; if (an !== ea) begin
        failures++; $display("FAIL scan_an7 edge=%0d got=%b exp=%b", n, an, ea);
      end
      if (n == n_load + 5) begin
        e = exp_q.pop_front();
        checks++; if (done !== 1'b1 || {bcd_tens, bcd_units} !== e) begin
          failures++; $display("FAIL scan_conv7 got done=%b bcd=%h exp done=1 bcd=%h", done, {bcd_tens, bcd_units}, e);
        end
      end
      if (n >= n_load + 5) begin
        es = (ea == 2'b10) ? pat(7) : tens_blank;
        checks++; if (seg !== es) begin
          failures++; $display("FAIL scan_seg7 edge=%0d an=%b got=%b exp=%b", n, an, seg, es);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; sum_in = 5'd0;
    test_reset();
    test_conversion();
    test_sweep();
    test_ignored_loads();
    test_reset_mid();
    test_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
